// File: rtl/display_pkg.sv
// Shared types and constants for the display update sequencer.
package display_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Command words per window: CASET + 4 params, PASET + 4 params, RAMWR.
  localparam int CMD_WORDS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PIX_HI,
    ST_PIX_LO
  } seq_state_t;

  // {dc, byte}: dc=0 command, dc=1 parameter or pixel data.
  typedef logic [8:0] disp_word_t;

endpackage

// File: rtl/display_cmd_rom.sv
// Combinational command table: maps a command index and the latched
// window coordinates to the {dc, byte} word sent during the CMD phase.
module display_cmd_rom
  import display_pkg::*;
#(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 9
) (
  input  logic [3:0]        idx,
  input  logic [X_BITS-1:0] x0,
  input  logic [X_BITS-1:0] x1,
  input  logic [Y_BITS-1:0] y0,
  input  logic [Y_BITS-1:0] y1,
  output disp_word_t        word
);

  logic [15:0] x0_ext, x1_ext, y0_ext, y1_ext;

  assign x0_ext = 16'(x0);
  assign x1_ext = 16'(x1);
  assign y0_ext = 16'(y0);
  assign y1_ext = 16'(y1);

  // Table lookup; out-of-range indices return an all-zero word.
  always_comb begin
    word = '0;
    case (idx)
      4'd0:  word = {1'b0, CMD_CASET};
      4'd1:  word = {1'b1, x0_ext[15:8]};
      4'd2:  word = {1'b1, x0_ext[7:0]};
      4'd3:  word = {1'b1, x1_ext[15:8]};
      4'd4:  word = {1'b1, x1_ext[7:0]};
      4'd5:  word = {1'b0, CMD_PASET};
      4'd6:  word = {1'b1, y0_ext[15:8]};
      4'd7:  word = {1'b1, y0_ext[7:0]};
      4'd8:  word = {1'b1, y1_ext[15:8]};
      4'd9:  word = {1'b1, y1_ext[7:0]};
      4'd10: word = {1'b0, CMD_RAMWR};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/display_update_sequencer.sv
// Window update sequencer: emits CASET/PASET/RAMWR command words and then
// forwards the window's RGB565 pixels as high/low byte pairs.
// Optional build macro: DISPLAY_SEQ_TLAST_CHECK_EN enables checking of the
// producer's s_axis_tlast against the internal pixel count (sets err).
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ST_IDLE   | waiting for a window request; req_ready high
// ST_CMD    | loading the remaining command words into the output register
// ST_PIX_HI | waiting for a pixel, then loading its high byte
// ST_PIX_LO | loading the low byte; with count at 0, waiting final handshake
module display_update_sequencer
  import display_pkg::*;
#(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 9
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [X_BITS-1:0] req_x0,
  input  logic [X_BITS-1:0] req_x1,
  input  logic [Y_BITS-1:0] req_y0,
  input  logic [Y_BITS-1:0] req_y1,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [15:0]       s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [8:0]        m_axis_tdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = X_BITS + Y_BITS + 2;

  seq_state_t        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [X_BITS-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [Y_BITS-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [15:0]       pix_q, pix_d;
  logic              pix_full_q, pix_full_d;
  logic              m_valid_q, m_valid_d;
  disp_word_t        m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              slot_free;
  logic              s_hs;
  logic              req_bad;
  logic [X_BITS:0]   req_w;
  logic [Y_BITS:0]   req_h;
  logic [CW-1:0]     req_cnt;
  disp_word_t        rom_word;

  display_cmd_rom #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_cmd_rom (
    .idx (idx_q),
    .x0  (x0_q),
    .x1  (x1_q),
    .y0  (y0_q),
    .y1  (y1_q),
    .word(rom_word)
  );

  // Output register can take a new word when empty or being consumed.
  assign slot_free     = !m_valid_q || m_axis_tready;
  assign s_axis_tready = (state_q == ST_PIX_HI) && !pix_full_q;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  assign req_ready     = (state_q == ST_IDLE) && !reset;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

`ifndef DISPLAY_SEQ_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  // Request validation and pixel count, evaluated on the raw request inputs.
  always_comb begin
    req_bad = (req_x1 < req_x0) || (req_y1 < req_y0);
    req_w   = {1'b0, req_x1} - {1'b0, req_x0} + (X_BITS + 1)'(1);
    req_h   = {1'b0, req_y1} - {1'b0, req_y0} + (Y_BITS + 1)'(1);
    req_cnt = CW'(req_w) * CW'(req_h);
  end

  // Next-state and output-register loading.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    pix_d      = pix_q;
    pix_full_d = pix_full_q;
    m_valid_d  = m_valid_q && !m_axis_tready;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          x0_d  = req_x0;
          x1_d  = req_x1;
          y0_d  = req_y0;
          y1_d  = req_y1;
          err_d = 1'b0;
          if (req_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            // First command word goes out directly so it is valid next cycle.
            cnt_d     = req_cnt;
            idx_d     = 4'd1;
            m_valid_d = 1'b1;
            m_data_d  = {1'b0, CMD_CASET};
            m_last_d  = 1'b0;
            state_d   = ST_CMD;
          end
        end
      end

      ST_CMD: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = rom_word;
          m_last_d  = 1'b0;
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'(CMD_WORDS - 1)) begin
            idx_d   = 4'd0;
            state_d = ST_PIX_HI;
          end
        end
      end

      ST_PIX_HI: begin
        if (s_hs) begin
          pix_d      = s_axis_tdata;
          pix_full_d = 1'b1;
`ifdef DISPLAY_SEQ_TLAST_CHECK_EN
          if (s_axis_tlast != (cnt_q == CW'(1))) begin
            err_d = 1'b1;
          end
`endif
        end
        // A pixel arriving this cycle is bypassed straight to the output.
        if (slot_free && (pix_full_q || s_hs)) begin
          m_valid_d = 1'b1;
          m_data_d  = {1'b1, pix_full_q ? pix_q[15:8] : s_axis_tdata[15:8]};
          m_last_d  = 1'b0;
          state_d   = ST_PIX_LO;
        end
      end

      ST_PIX_LO: begin
        if (cnt_q == '0) begin
          if (m_valid_q && m_axis_tready) begin
            done_d   = 1'b1;
            m_last_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else if (slot_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = {1'b1, pix_q[7:0]};
          m_last_d   = (cnt_q == CW'(1));
          pix_full_d = 1'b0;
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q != CW'(1)) begin
            state_d = ST_PIX_HI;
          end
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      pix_q      <= '0;
      pix_full_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      pix_q      <= pix_d;
      pix_full_q <= pix_full_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_display_update_sequencer.sv
// Self-checking bench for display_update_sequencer: a word-list model built
// from window coordinates and pixel data, random stalls, reset and error cases.
module tb_display_update_sequencer;

  localparam int XB = 9;
  localparam int YB = 9;

  logic          aclk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [XB-1:0] req_x0, req_x1;
  logic [YB-1:0] req_y0, req_y1;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [15:0]   s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [8:0]    m_axis_tdata;
  logic          busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [15:0] pix_mem[$];
  logic [8:0]  exp_q[$];

  display_update_sequencer #(.X_BITS(XB), .Y_BITS(YB)) dut (
    .aclk(aclk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference word list: three address/command groups, then hi/lo per pixel.
  task automatic build_expect(input int x0, input int y0, input int x1, input int y1);
    logic [15:0] c0, c1, c2, c3, px;
    c0 = 16'(x0); c1 = 16'(x1); c2 = 16'(y0); c3 = 16'(y1);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, c0[15:8]}); exp_q.push_back({1'b1, c0[7:0]});
    exp_q.push_back({1'b1, c1[15:8]}); exp_q.push_back({1'b1, c1[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, c2[15:8]}); exp_q.push_back({1'b1, c2[7:0]});
    exp_q.push_back({1'b1, c3[15:8]}); exp_q.push_back({1'b1, c3[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < pix_mem.size(); i++) begin
      px = pix_mem[i];
      exp_q.push_back({1'b1, px[15:8]});
      exp_q.push_back({1'b1, px[7:0]});
    end
  endtask

  task automatic send_req(input int x0, input int y0, input int x1, input int y1, input string name);
    @(posedge aclk); #1;
    req_valid = 1'b1;
    req_x0 = XB'(x0); req_x1 = XB'(x1); req_y0 = YB'(y0); req_y1 = YB'(y1);
    @(negedge aclk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready before accept: got=%b want=1", name, req_ready);
    end
    @(posedge aclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drive_cycle(input bit stall, input int p, input int npix, input int bad_last);
    m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (p < pix_mem.size() && p < npix) begin
      s_axis_tvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_tdata  = pix_mem[p];
      s_axis_tlast  = (bad_last >= 0) ? (p == bad_last) : (p == npix - 1);
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic run_window(input int x0, input int y0, input int x1, input int y1,
                            input bit stall, input int bad_last, input int stop_pix,
                            input bit exp_err, input string name);
    int npix, n_words, k, p, done_cnt, last_hs, tail, budget;
    bit prev_stall;
    logic [8:0] prev_data;
    npix = (x1 - x0 + 1) * (y1 - y0 + 1);
    n_words = 11 + 2 * npix;
    k = 0; p = 0; done_cnt = 0; last_hs = -1; tail = 0; prev_stall = 0; prev_data = '0;
    budget = (stop_pix >= 0) ? 200 : 100 + 10 * n_words;
    build_expect(x0, y0, x1, y1);
    send_req(x0, y0, x1, y1, name);
    drive_cycle(stall, p, npix, bad_last);
    @(negedge aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 9'h02A) begin
      errors++;
      $display("FAIL %s first word latency: valid=%b data=%h want valid=1 data=02a", name, m_axis_tvalid, m_axis_tdata);
    end
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL %s hold under stall: valid=%b data=%h want valid=1 data=%h", name, m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        checks++;
        if (k >= exp_q.size()) begin
          errors++; $display("FAIL %s extra word: got=%h want none", name, m_axis_tdata);
        end else if (m_axis_tdata !== exp_q[k] || m_axis_tlast !== (k == n_words - 1)) begin
          errors++;
          $display("FAIL %s word %0d: got data=%h last=%b want data=%h last=%b",
                   name, k, m_axis_tdata, m_axis_tlast, exp_q[k], (k == n_words - 1));
        end
        last_hs = cyc;
        k++;
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      prev_data  = m_axis_tdata;
      if (s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) p++;
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (k !== n_words) begin
          errors++; $display("FAIL %s done timing: words seen=%0d want %0d", name, k, n_words);
        end
      end
      if (stop_pix >= 0 && p >= stop_pix) return;
      if (done_cnt > 0) tail++;
      if (tail > 3) break;
      @(posedge aclk); #1;
      drive_cycle(stall && done_cnt == 0, p, npix, bad_last);
      @(negedge aclk);
    end
    checks++;
    if (k !== n_words || p !== npix || done_cnt !== 1) begin
      errors++;
      $display("FAIL %s totals: words=%0d pixels=%0d dones=%0d want %0d %0d 1", name, k, p, done_cnt, n_words, npix);
    end
    checks++;
    if (err !== exp_err || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s end state: err=%b busy=%b req_ready=%b want err=%b busy=0 req_ready=1", name, err, busy, req_ready, exp_err);
    end
    if (!stall) begin
      checks++;
      if (last_hs !== n_words - 1) begin
        errors++; $display("FAIL %s throughput: last word at cycle %0d want %0d", name, last_hs, n_words - 1);
      end
    end
  endtask

  task automatic fill_pixels(input int n);
    pix_mem.delete();
    for (int i = 0; i < n; i++) pix_mem.push_back(16'($urandom));
  endtask

  task automatic check_reset_outputs(input string name, input logic want_ready);
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 9'h000 || m_axis_tlast !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || s_axis_tready !== 1'b0 || req_ready !== want_ready) begin
      errors++;
      $display("FAIL %s reset outputs: v=%b d=%h l=%b busy=%b done=%b err=%b srdy=%b rrdy=%b want all 0, rrdy=%b",
               name, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done, err, s_axis_tready, req_ready, want_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset_hold", 1'b0);
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("reset_release", 1'b1);
  endtask

  task automatic test_single_pixel();
    pix_mem.delete();
    pix_mem.push_back(16'hABCD);
    run_window(5, 7, 5, 7, 1'b0, -1, -1, 1'b0, "one_by_one");
  endtask

  task automatic test_random_windows();
    int x0, y0, w, h;
    for (int i = 0; i < 6; i++) begin
      x0 = $urandom_range(0, 315); w = $urandom_range(1, 4);
      y0 = $urandom_range(0, 476); h = $urandom_range(1, 3);
      fill_pixels(w * h);
      run_window(x0, y0, x0 + w - 1, y0 + h - 1, i[0], -1, -1, 1'b0, "random_window");
    end
  endtask

  task automatic test_stall();
    fill_pixels(6);
    run_window(40, 300, 42, 301, 1'b0, -1, -1, 1'b0, "stall_ref");
    run_window(40, 300, 42, 301, 1'b1, -1, -1, 1'b0, "stall_3x2");
  endtask

  task automatic test_invalid(input int x0, input int y0, input int x1, input int y1, input string name);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    send_req(x0, y0, x1, y1, name);
    @(negedge aclk);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || req_ready !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s reject: done=%b err=%b rrdy=%b mvalid=%b busy=%b want 1 1 1 0 0", name, done, err, req_ready, m_axis_tvalid, busy);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL %s after reject: done=%b err=%b mvalid=%b want 0 1 0", name, done, err, m_axis_tvalid);
    end
  endtask

  task automatic test_err_clear();
    fill_pixels(2);
    run_window(100, 3, 101, 3, 1'b0, -1, -1, 1'b0, "err_cleared");
  endtask

  task automatic test_tlast_check();
    bit exp_e;
`ifdef DISPLAY_SEQ_TLAST_CHECK_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    fill_pixels(4);
    run_window(8, 9, 9, 10, 1'b0, 1, -1, exp_e, "tlast_check");
  endtask

  task automatic test_back_to_back();
    fill_pixels(3);
    run_window(0, 0, 2, 0, 1'b0, -1, -1, 1'b0, "b2b_first");
    fill_pixels(2);
    run_window(319, 478, 319, 479, 1'b0, -1, -1, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    fill_pixels(8);
    run_window(0, 0, 319, 479, 1'b0, -1, 3, 1'b0, "full_screen");
    @(posedge aclk); #1;
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset_mid", 1'b0);
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("reset_mid_release", 1'b1);
    fill_pixels(2);
    run_window(10, 20, 11, 20, 1'b0, -1, -1, 1'b0, "after_reset");
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    test_reset();
    test_single_pixel();
    test_random_windows();
    test_stall();
    test_invalid(10, 0, 5, 0, "bad_x");
    test_invalid(0, 9, 0, 4, "bad_y");
    test_err_clear();
    test_tlast_check();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
